// File: rtl/queue_calc_ctrl.sv
// queue_calc_ctrl
//   Sequencer for the queue calculator. Takes one command at a time, owns the
//   DEPTH x 8 circular operand queue, pops operands into the external
//   combinational ALU, writes the ALU result back at the queue tail and returns
//   one response per command.
//
// Ports
//   clk, rst               clock (rising edge), async active-high reset
//   cmd_valid/cmd_ready    command handshake (ready only in IDLE)
//   cmd_op, cmd_val        opcode (0 PUSH,1 POP,2 ADD,3 MUL,4 SUB,5 DIV,6 REM), push value
//   alu_operands           {op_b, op_a} to the ALU
//   alu_opcode             registered opcode to the ALU (SLEEP_OP when idle)
//   alu_push_val           registered push value to the ALU
//   alu_result             ALU result
//   alu_queue_op           ALU queue action (00 push, 11 pop, 10 get-and-push, 01 sleep)
//   alu_calc_err           ALU calculation-error flag (sticky in the ALU)
//   rsp_valid              one-cycle response strobe
//   rsp_data, rsp_err      response payload / error code
//   q_count, q_empty, q_full  queue occupancy status
module queue_calc_ctrl #(
  parameter int          DEPTH    = 16,
  parameter int          ADDR_W   = 4,
  parameter logic [3:0]  SLEEP_OP = 4'b1111
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [3:0]        cmd_op,
  input  logic [7:0]        cmd_val,
  output logic [15:0]       alu_operands,
  output logic [3:0]        alu_opcode,
  output logic [7:0]        alu_push_val,
  input  logic [7:0]        alu_result,
  input  logic [1:0]        alu_queue_op,
  input  logic              alu_calc_err,
  output logic              rsp_valid,
  output logic [7:0]        rsp_data,
  output logic [2:0]        rsp_err,
  output logic [ADDR_W:0]   q_count,
  output logic              q_empty,
  output logic              q_full
);

  localparam logic [3:0] OP_PUSH = 4'd0;
  localparam logic [3:0] OP_POP  = 4'd1;
  localparam logic [3:0] OP_ADD  = 4'd2;
  localparam logic [3:0] OP_DIV  = 4'd5;
  localparam logic [3:0] OP_REM  = 4'd6;

  localparam logic [2:0] E_OK   = 3'b000;
  localparam logic [2:0] E_UNDR = 3'b001;
  localparam logic [2:0] E_OVR  = 3'b010;
  localparam logic [2:0] E_DIV0 = 3'b011;
  localparam logic [2:0] E_ILL  = 3'b100;

  typedef enum logic [2:0] {
    S_IDLE, S_CHECK, S_READ_A, S_READ_B, S_EXEC, S_WRITE, S_RESP
  } state_e;

  state_e            state_q, state_d;
  logic [7:0]        mem [DEPTH];
  logic [ADDR_W-1:0] head_q, tail_q;
  logic [ADDR_W:0]   count_q;
  logic [3:0]        op_q;
  logic [7:0]        op_a_q, op_b_q;
  logic [3:0]        alu_opcode_q;
  logic [7:0]        alu_push_val_q;
  logic [7:0]        res_q;
  logic [2:0]        err_q;
  logic              rsp_valid_q;
  logic [7:0]        rsp_data_q;
  logic [2:0]        rsp_err_q;

  logic              is_bin, is_divrem, is_illegal;
  logic [2:0]        chk_err;
  logic              wr_err, wr_push;

  assign is_illegal = (op_q > OP_REM);
  assign is_bin     = (op_q >= OP_ADD) && (op_q <= OP_REM);
  assign is_divrem  = (op_q == OP_DIV) || (op_q == OP_REM);

  // Admission check; error paths leave the queue untouched.
  always_comb begin
    chk_err = E_OK;
    if (is_illegal)                                  chk_err = E_ILL;
    else if ((op_q == OP_PUSH) && q_full)            chk_err = E_OVR;
    else if ((op_q == OP_POP) && q_empty)            chk_err = E_UNDR;
    else if (is_bin && (count_q < (ADDR_W+1)'(2)))   chk_err = E_UNDR;
  end

  // The ALU error flag is sticky, so it is only trusted for DIV/REM.
  assign wr_err  = is_divrem && (alu_calc_err || (op_b_q == 8'd0));
  assign wr_push = !wr_err && ((alu_queue_op == 2'b00) || (alu_queue_op == 2'b10));

  // Next-state / handshake
  always_comb begin
    state_d   = state_q;
    cmd_ready = 1'b0;
    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) state_d = S_CHECK;
      end
      S_CHECK: begin
        if (chk_err != E_OK)       state_d = S_RESP;
        else if (op_q == OP_PUSH)  state_d = S_EXEC;
        else                       state_d = S_READ_A;
      end
      S_READ_A: state_d = is_bin ? S_READ_B : S_EXEC;
      S_READ_B: state_d = S_EXEC;
      S_EXEC:   state_d = S_WRITE;
      S_WRITE:  state_d = S_RESP;
      S_RESP:   state_d = S_IDLE;
      default:  state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_q <= S_IDLE;
    else     state_q <= state_d;
  end

  // Datapath registers
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_q         <= '0;
      tail_q         <= '0;
      count_q        <= '0;
      op_q           <= '0;
      op_a_q         <= '0;
      op_b_q         <= '0;
      alu_opcode_q   <= SLEEP_OP;
      alu_push_val_q <= '0;
      res_q          <= '0;
      err_q          <= '0;
      rsp_valid_q    <= 1'b0;
      rsp_data_q     <= '0;
      rsp_err_q      <= '0;
    end else begin
      rsp_valid_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (cmd_valid) begin
            op_q           <= cmd_op;
            alu_opcode_q   <= cmd_op;
            alu_push_val_q <= cmd_val;
            op_a_q         <= '0;
            op_b_q         <= '0;
          end
        end
        S_CHECK: begin
          if (chk_err != E_OK) begin
            err_q <= chk_err;
            res_q <= '0;
          end
        end
        S_READ_A: begin
          op_a_q  <= mem[head_q];
          head_q  <= head_q + 1'b1;
          count_q <= count_q - 1'b1;
        end
        S_READ_B: begin
          op_b_q  <= mem[head_q];
          head_q  <= head_q + 1'b1;
          count_q <= count_q - 1'b1;
        end
        S_WRITE: begin
          if (wr_err) begin
            // Consumed operands are dropped; nothing goes back on the queue.
            err_q <= E_DIV0;
            res_q <= '0;
          end else begin
            err_q <= E_OK;
            res_q <= (op_q == OP_POP) ? op_a_q : alu_result;
            if (wr_push) begin
              tail_q  <= tail_q + 1'b1;
              count_q <= count_q + 1'b1;
            end
          end
        end
        S_RESP: begin
          rsp_valid_q  <= 1'b1;
          rsp_data_q   <= res_q;
          rsp_err_q    <= err_q;
          alu_opcode_q <= SLEEP_OP;
        end
        default: ;
      endcase
    end
  end

  // Queue storage is not reset. Full PUSH never reaches WRITE, and binary ops
  // free two entries before pushing one, so this write cannot overflow.
  always_ff @(posedge clk) begin
    if ((state_q == S_WRITE) && wr_push) mem[tail_q] <= alu_result;
  end

  assign alu_operands = {op_b_q, op_a_q};
  assign alu_opcode   = alu_opcode_q;
  assign alu_push_val = alu_push_val_q;
  assign rsp_valid    = rsp_valid_q;
  assign rsp_data     = rsp_data_q;
  assign rsp_err      = rsp_err_q;
  assign q_count      = count_q;
  assign q_empty      = (count_q == '0);
  assign q_full       = (count_q == (ADDR_W+1)'(DEPTH));

endmodule
